// File: rtl/turn_signal_controller.sv
// ---------------------------------------------------------------------------
// turn_signal_controller
//
// Generates turn-signal and hazard flash patterns. Raw stalk and hazard
// inputs are synchronized and debounced, hazard is a push-on/push-off latch,
// and a short stalk tap produces a fixed number of "comfort" flashes. The
// blink level on turn_signal_on feeds the sound unit, which clicks on every
// edge of it.
//
// Parameters
//   DEBOUNCE_CYCLES   : stable cycles required before a debounced input moves
//   BLINK_HALF_CYCLES : length of every on-phase and every off-phase
//   TAP_CYCLES        : stalk holds shorter than this count as a tap
//   COMFORT_FLASHES   : total on-phases produced by a tap (fits in 2 bits)
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   sw_left        in   raw left stalk level (asynchronous)
//   sw_right       in   raw right stalk level (asynchronous)
//   sw_hazard      in   raw hazard push-button (asynchronous)
//   engine_on      in   engine running (synchronous to clk)
//   turn_signal_on out  blink state for the sound unit
//   lamp_left      out  left lamp drive
//   lamp_right     out  right lamp drive
//   blink_mode     out  current state encoding (0..5)
// ---------------------------------------------------------------------------
module turn_signal_controller #(
    parameter int unsigned DEBOUNCE_CYCLES   = 500_000,
    parameter int unsigned BLINK_HALF_CYCLES = 16_666_667,
    parameter int unsigned TAP_CYCLES        = 25_000_000,
    parameter int unsigned COMFORT_FLASHES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_left,
    input  logic       sw_right,
    input  logic       sw_hazard,
    input  logic       engine_on,
    output logic       turn_signal_on,
    output logic       lamp_left,
    output logic       lamp_right,
    output logic [2:0] blink_mode
);

    // -----------------------------------------------------------------------
    // Widths and constants
    // -----------------------------------------------------------------------
    localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES   > 1) ? $clog2(DEBOUNCE_CYCLES + 1)   : 1;
    localparam int unsigned PH_W   = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES + 1) : 1;
    localparam int unsigned HOLD_W = $clog2(TAP_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(BLINK_HALF_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(TAP_CYCLES);
    localparam logic [1:0]        FLASH_MAX = 2'(COMFORT_FLASHES);

    // Channel indices into the conditioning arrays
    localparam int unsigned CH_L = 0;
    localparam int unsigned CH_R = 1;
    localparam int unsigned CH_H = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEFT   = 3'd1,
        ST_RIGHT  = 3'd2,
        ST_HAZARD = 3'd3,
        ST_COMF_L = 3'd4,
        ST_COMF_R = 3'd5
    } state_e;

    // -----------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizer + debounce per channel
    // -----------------------------------------------------------------------
    logic [2:0]       raw_s;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       deb_q;
    logic [2:0]       deb_d;
    logic [DEB_W-1:0] deb_cnt_q [3];
    logic [DEB_W-1:0] deb_cnt_d [3];
    logic             haz_lat_q;
    logic             haz_lat_d;

    assign raw_s = {sw_hazard, sw_right, sw_left};

    // Debounce next-state: a channel moves only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i]     = sync2_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end else begin
                deb_cnt_d[i] = '0;
            end
        end
        // Toggle on the same edge the debounced hazard rises, so the state
        // machine reacts one cycle after the debounced edge.
        haz_lat_d = haz_lat_q ^ (deb_d[CH_H] & ~deb_q[CH_H]);
    end

    // Conditioning registers: synchronizers, debounced levels, hazard latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 3'b000;
            sync2_q   <= 3'b000;
            deb_q     <= 3'b000;
            haz_lat_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= raw_s;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            haz_lat_q <= haz_lat_d;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // State machine, counters and blink generator
    // -----------------------------------------------------------------------
    state_e            state_q;
    state_e            state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [1:0]        flash_cnt_q;
    logic [1:0]        flash_cnt_d;
    logic [1:0]        flash_base_s;
    logic [PH_W-1:0]   phase_cnt_q;
    logic [PH_W-1:0]   phase_cnt_d;
    logic              blink_q;
    logic              blink_d;
    logic              turn_q;
    logic              lamp_l_q;
    logic              lamp_r_q;
    logic [2:0]        mode_q;

    logic left_s;
    logic right_s;
    logic phase_end_s;
    logic blink_fall_s;
    logic blink_rise_s;
    logic hold_rst_s;
    logic flash_rst_s;
    logic tap_ok_s;

    // Both stalk contacts closed is a fault and counts as neither direction.
    assign left_s       = deb_q[CH_L] & ~deb_q[CH_R];
    assign right_s      = deb_q[CH_R] & ~deb_q[CH_L];
    assign phase_end_s  = (phase_cnt_q == PH_LAST);
    assign blink_fall_s = blink_q & phase_end_s;
    assign tap_ok_s     = (hold_cnt_q < HOLD_MAX) && (flash_cnt_q < FLASH_MAX);

    // Next-state decode; hold_rst_s / flash_rst_s mark entries that restart
    // the tap timer and the comfort flash count.
    always_comb begin
        state_d     = state_q;
        hold_rst_s  = 1'b0;
        flash_rst_s = 1'b0;
        if (haz_lat_q) begin
            state_d = ST_HAZARD;
        end else begin
            case (state_q)
                ST_IDLE, ST_HAZARD: begin
                    // Leaving hazard drops any interrupted comfort sequence.
                    if (left_s && engine_on) begin
                        state_d     = ST_LEFT;
                        hold_rst_s  = 1'b1;
                        flash_rst_s = 1'b1;
                    end else if (right_s && engine_on) begin
                        state_d     = ST_RIGHT;
                        hold_rst_s  = 1'b1;
                        flash_rst_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LEFT: begin
                    if (!engine_on) begin
                        state_d = ST_IDLE;
                    end else if (left_s) begin
                        state_d = ST_LEFT;
                    end else if (right_s) begin
                        state_d     = ST_RIGHT;
                        hold_rst_s  = 1'b1;
                        flash_rst_s = 1'b1;
                    end else if (tap_ok_s) begin
                        state_d = ST_COMF_L;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RIGHT: begin
                    if (!engine_on) begin
                        state_d = ST_IDLE;
                    end else if (right_s) begin
                        state_d = ST_RIGHT;
                    end else if (left_s) begin
                        state_d     = ST_LEFT;
                        hold_rst_s  = 1'b1;
                        flash_rst_s = 1'b1;
                    end else if (tap_ok_s) begin
                        state_d = ST_COMF_R;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_COMF_L: begin
                    if (!engine_on) begin
                        state_d = ST_IDLE;
                    end else if (left_s) begin
                        // Re-asserting the same stalk keeps the flash count.
                        state_d    = ST_LEFT;
                        hold_rst_s = 1'b1;
                    end else if (right_s) begin
                        state_d     = ST_RIGHT;
                        hold_rst_s  = 1'b1;
                        flash_rst_s = 1'b1;
                    end else if (blink_fall_s && (flash_cnt_q == FLASH_MAX)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_COMF_L;
                    end
                end
                ST_COMF_R: begin
                    if (!engine_on) begin
                        state_d = ST_IDLE;
                    end else if (right_s) begin
                        state_d    = ST_RIGHT;
                        hold_rst_s = 1'b1;
                    end else if (left_s) begin
                        state_d     = ST_LEFT;
                        hold_rst_s  = 1'b1;
                        flash_rst_s = 1'b1;
                    end else if (blink_fall_s && (flash_cnt_q == FLASH_MAX)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_COMF_R;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Blink generator and counters. Moves between non-idle states leave the
    // phase running so the flash rhythm never stutters.
    always_comb begin
        blink_d     = blink_q;
        phase_cnt_d = phase_cnt_q;
        if (state_d == ST_IDLE) begin
            blink_d     = 1'b0;
            phase_cnt_d = '0;
        end else if (state_q == ST_IDLE) begin
            blink_d     = 1'b1;
            phase_cnt_d = '0;
        end else if (phase_end_s) begin
            blink_d     = ~blink_q;
            phase_cnt_d = '0;
        end else begin
            blink_d     = blink_q;
            phase_cnt_d = phase_cnt_q + PH_W'(1);
        end

        blink_rise_s = blink_d & ~blink_q;

        // flash_cnt numbers the current on-phase; saturates at FLASH_MAX.
        flash_base_s = flash_rst_s ? 2'd0 : flash_cnt_q;
        if (state_d == ST_IDLE) begin
            flash_cnt_d = 2'd0;
        end else if (blink_rise_s && (flash_base_s != FLASH_MAX)) begin
            flash_cnt_d = flash_base_s + 2'd1;
        end else begin
            flash_cnt_d = flash_base_s;
        end

        // Tap timer only runs while the stalk is actively held.
        if ((state_d == ST_LEFT) || (state_d == ST_RIGHT)) begin
            if (hold_rst_s) begin
                hold_cnt_d = '0;
            end else if (hold_cnt_q < HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end else begin
                hold_cnt_d = hold_cnt_q;
            end
        end else begin
            hold_cnt_d = '0;
        end
    end

    // FSM state, counters and registered outputs; outputs show the state and
    // blink level of the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            flash_cnt_q <= 2'd0;
            phase_cnt_q <= '0;
            blink_q     <= 1'b0;
            turn_q      <= 1'b0;
            lamp_l_q    <= 1'b0;
            lamp_r_q    <= 1'b0;
            mode_q      <= 3'd0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            blink_q     <= blink_d;
            turn_q      <= (state_q != ST_IDLE) & blink_q;
            lamp_l_q    <= (state_q != ST_IDLE) & blink_q &
                           ((state_q == ST_LEFT) || (state_q == ST_COMF_L) ||
                            (state_q == ST_HAZARD));
            lamp_r_q    <= (state_q != ST_IDLE) & blink_q &
                           ((state_q == ST_RIGHT) || (state_q == ST_COMF_R) ||
                            (state_q == ST_HAZARD));
            mode_q      <= state_q;
        end
    end

    assign turn_signal_on = turn_q;
    assign lamp_left      = lamp_l_q;
    assign lamp_right     = lamp_r_q;
    assign blink_mode     = mode_q;

endmodule

// File: tb/tb_turn_signal_controller.sv
// ---------------------------------------------------------------------------
// tb_turn_signal_controller
//
// Directed-vector bench for turn_signal_controller with small parameters
// (debounce 4, half period 10, tap 30, 3 comfort flashes). Every expected
// value below is a hand-computed constant at a known cycle offset from the
// point where the stimulus was applied (Pn = n-th rising edge after it).
// ---------------------------------------------------------------------------
module tb_turn_signal_controller;

    logic       clk;
    logic       rst;
    logic       sw_left;
    logic       sw_right;
    logic       sw_hazard;
    logic       engine_on;
    logic       turn_signal_on;
    logic       lamp_left;
    logic       lamp_right;
    logic [2:0] blink_mode;

    int tests_run;
    int tests_failed;

    turn_signal_controller #(
        .DEBOUNCE_CYCLES  (4),
        .BLINK_HALF_CYCLES(10),
        .TAP_CYCLES       (30),
        .COMFORT_FLASHES  (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sw_left       (sw_left),
        .sw_right      (sw_right),
        .sw_hazard     (sw_hazard),
        .engine_on     (engine_on),
        .turn_signal_on(turn_signal_on),
        .lamp_left     (lamp_left),
        .lamp_right    (lamp_right),
        .blink_mode    (blink_mode)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Check all four outputs at once
    task automatic check_out(input string tag, input logic [2:0] mode,
                             input logic turn, input logic ll, input logic lr);
        check_val({tag, ".mode"}, 32'(blink_mode), 32'(mode));
        check_val({tag, ".turn"}, 32'(turn_signal_on), 32'(turn));
        check_val({tag, ".lamp_l"}, 32'(lamp_left), 32'(ll));
        check_val({tag, ".lamp_r"}, 32'(lamp_right), 32'(lr));
    endtask

    // Reset with all switches released; returns at P0+1 with rst low
    task automatic do_reset(input logic eng);
        rst       = 1'b1;
        sw_left   = 1'b0;
        sw_right  = 1'b0;
        sw_hazard = 1'b0;
        engine_on = eng;
        tick(3);
        rst = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // ---- reset state ----
        do_reset(1'b1);
        check_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);

        // ---- 1: steady left ----
        do_reset(1'b1);
        sw_left = 1'b1;
        tick(7);  check_val("t1.mode_p7", 32'(blink_mode), 32'd0);
        tick(1);  check_out("t1.p8", 3'd1, 1'b1, 1'b1, 1'b0);
        tick(9);  check_out("t1.p17", 3'd1, 1'b1, 1'b1, 1'b0);
        tick(1);  check_out("t1.p18", 3'd1, 1'b0, 1'b0, 1'b0);
        tick(9);  check_val("t1.p27_l", 32'(lamp_left), 32'd0);
        tick(1);  check_out("t1.p28", 3'd1, 1'b1, 1'b1, 1'b0);

        // ---- 2: tap -> comfort, exactly three flashes ----
        do_reset(1'b1);
        sw_left = 1'b1;
        tick(15); sw_left = 1'b0;
        tick(7);  check_val("t2.p22_mode", 32'(blink_mode), 32'd1);
        tick(1);  check_out("t2.p23", 3'd4, 1'b0, 1'b0, 1'b0);
        tick(5);  check_out("t2.p28", 3'd4, 1'b1, 1'b1, 1'b0);
        tick(20); check_out("t2.p48", 3'd4, 1'b1, 1'b1, 1'b0);
        tick(9);  check_out("t2.p57", 3'd4, 1'b1, 1'b1, 1'b0);
        tick(1);  check_out("t2.p58", 3'd0, 1'b0, 1'b0, 1'b0);
        tick(15); check_out("t2.p73", 3'd0, 1'b0, 1'b0, 1'b0);

        // ---- 3: hazard with engine off, second press clears ----
        do_reset(1'b0);
        sw_hazard = 1'b1;
        tick(8);  check_out("t3.p8", 3'd3, 1'b1, 1'b1, 1'b1);
        sw_hazard = 1'b0;
        tick(10); check_out("t3.p18", 3'd3, 1'b0, 1'b0, 1'b0);
        tick(10); check_out("t3.p28", 3'd3, 1'b1, 1'b1, 1'b1);
        tick(2);  sw_hazard = 1'b1;
        tick(7);  check_val("t3.p37_mode", 32'(blink_mode), 32'd3);
        tick(1);  check_out("t3.p38", 3'd0, 1'b0, 1'b0, 1'b0);
        tick(2);  sw_hazard = 1'b0;
        tick(12); check_out("t3.settle", 3'd0, 1'b0, 1'b0, 1'b0);

        // ---- 4: hazard during left, phase continuity, back to left ----
        do_reset(1'b1);
        sw_left = 1'b1;
        tick(11); sw_hazard = 1'b1;
        tick(7);  check_val("t4.p18_mode", 32'(blink_mode), 32'd1);
        tick(1);  check_out("t4.p19", 3'd3, 1'b0, 1'b0, 1'b0);
        sw_hazard = 1'b0;
        tick(9);  check_out("t4.p28", 3'd3, 1'b1, 1'b1, 1'b1);
        tick(2);  sw_hazard = 1'b1;
        tick(7);  check_out("t4.p37", 3'd3, 1'b1, 1'b1, 1'b1);
        tick(1);  check_out("t4.p38", 3'd1, 1'b0, 1'b0, 1'b0);
        sw_hazard = 1'b0;
        tick(10); check_out("t4.p48", 3'd1, 1'b1, 1'b1, 1'b0);

        // ---- 5: glitch rejection and stalk fault ----
        do_reset(1'b1);
        sw_right = 1'b1;
        tick(3);  sw_right = 1'b0;
        tick(12); check_out("t5.glitch", 3'd0, 1'b0, 1'b0, 1'b0);
        sw_left  = 1'b1;
        sw_right = 1'b1;
        tick(15); check_out("t5.fault", 3'd0, 1'b0, 1'b0, 1'b0);
        sw_left  = 1'b0;
        sw_right = 1'b0;

        // ---- 6: asynchronous reset mid on-phase ----
        do_reset(1'b1);
        sw_right = 1'b1;
        tick(12); check_out("t6.p12", 3'd2, 1'b1, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1 check_out("t6.async", 3'd0, 1'b0, 1'b0, 1'b0);
        tick(2);  rst = 1'b0;
        tick(7);  check_val("t6.q7_mode", 32'(blink_mode), 32'd0);
        tick(1);  check_out("t6.q8", 3'd2, 1'b1, 1'b0, 1'b1);

        // ---- 7: release after tap window -> idle, no comfort ----
        do_reset(1'b1);
        sw_left = 1'b1;
        tick(40); sw_left = 1'b0;
        tick(7);  check_val("t7.p47_mode", 32'(blink_mode), 32'd1);
        tick(1);  check_out("t7.p48", 3'd0, 1'b0, 1'b0, 1'b0);

        // ---- 8: engine off cuts an on-phase short ----
        do_reset(1'b1);
        sw_left = 1'b1;
        tick(11); engine_on = 1'b0;
        tick(1);  check_out("t8.p12", 3'd1, 1'b1, 1'b1, 1'b0);
        tick(1);  check_out("t8.p13", 3'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
